// File: rtl/iomem_timer.sv
// iomem_timer: memory-mapped prescaled 32-bit timer with compare match,
// auto-reload or one-shot mode, and a registered level interrupt.
module iomem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq_out
);
    logic        r_ready;
    logic [31:0] r_rdata;
    logic        r_irq;
    logic        r_en;
    logic        r_auto;
    logic        r_irqen;
    logic [15:0] r_prescale;
    logic [15:0] r_ps;
    logic [31:0] r_compare;
    logic [31:0] r_count;
    logic        r_match;

    logic        w_acc;
    logic        w_we;
    logic [5:0]  w_off;
    logic [31:0] w_mask;
    logic        w_wr_ctrl;
    logic        w_wr_pre;
    logic        w_wr_cmp;
    logic        w_wr_cnt;
    logic        w_clr;
    logic        w_tick;
    logic        w_hit;
    logic [31:0] w_rd;
    logic        w_unused;

    assign w_acc     = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8] && !r_ready;
    assign w_we      = w_acc && |iomem_wstrb;
    assign w_off     = iomem_addr[7:2];
    assign w_mask    = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign w_wr_ctrl = w_we && w_off == 6'd0 && iomem_wstrb[0];
    assign w_wr_pre  = w_we && w_off == 6'd1;
    assign w_wr_cmp  = w_we && w_off == 6'd2;
    assign w_wr_cnt  = w_we && w_off == 6'd3;
    assign w_clr     = w_we && w_off == 6'd4 && iomem_wstrb[0] && iomem_wdata[0];
    assign w_tick    = r_en && r_ps == r_prescale;
    assign w_hit     = w_tick && r_count == r_compare;
    assign w_unused  = &{1'b0, iomem_addr[1:0]};

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign irq_out     = r_irq;

    always_comb begin
        w_rd = '0;
        case (w_off)
            6'd0:    w_rd = {29'd0, r_irqen, r_auto, r_en};
            6'd1:    w_rd = {16'd0, r_prescale};
            6'd2:    w_rd = r_compare;
            6'd3:    w_rd = r_count;
            6'd4:    w_rd = {31'd0, r_match};
            default: w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ready    <= 1'b0;
            r_rdata    <= '0;
            r_irq      <= 1'b0;
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irqen    <= 1'b0;
            r_prescale <= '0;
            r_ps       <= '0;
            r_compare  <= '1;
            r_count    <= '0;
            r_match    <= 1'b0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_acc ? w_rd : '0;
            r_irq   <= r_match && r_irqen;
            // bus writes override the tick's one-shot disable and count update
            if (w_wr_ctrl)
                {r_irqen, r_auto, r_en} <= iomem_wdata[2:0];
            else if (w_hit && !r_auto)
                r_en <= 1'b0;
            r_ps <= ((w_wr_ctrl && !iomem_wdata[0]) || !r_en || w_tick) ? 16'd0 : r_ps + 16'd1;
            if (w_wr_pre)
                r_prescale <= (r_prescale & ~w_mask[15:0]) | (iomem_wdata[15:0] & w_mask[15:0]);
            if (w_wr_cmp)
                r_compare <= (r_compare & ~w_mask) | (iomem_wdata & w_mask);
            if (w_wr_cnt)
                r_count <= (r_count & ~w_mask) | (iomem_wdata & w_mask);
            else if (w_tick)
                r_count <= w_hit ? (r_auto ? 32'd0 : r_count) : r_count + 32'd1;
            if (w_hit)
                r_match <= 1'b1;
            else if (w_clr)
                r_match <= 1'b0;
        end
    end
endmodule
